// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the fetch buffer
//
// fetch_entry_t : one decoded-queue entry, instruction word tagged with its PC
// NOP_INSTR     : canonical RV32I no-op (addi x0, x0, 0)

package rv_fetch_pkg;

    typedef struct packed {
        logic [31:2] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/rv_fetch_fifo.sv
// rtl/rv_fetch_fifo.sv - synchronous FIFO with clear, used for the instruction queue and the PC tag queue
//
// Ports:
//   clk    in   clock, all state on rising edge
//   rst    in   asynchronous active-high reset
//   clr    in   synchronous clear; wins over push and pop in the same cycle
//   push   in   write wdata at the tail
//   wdata  in   WIDTH-bit write data
//   pop    in   drop the head entry
//   rdata  out  head entry (registered storage, no write-through)
//   count  out  current occupancy, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
//
// Push and pop together are legal at any occupancy, including full.

module rv_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign rdata = mem[rd_ptr];

    // A push into a full FIFO is only honoured when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty & ~clr;
    assign do_push = push & ~clr & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/rv_fetch_buf.sv
// rtl/rv_fetch_buf.sv - IMEM request issue, fetch queue and redirect handling for the fetch stage
//
// Ports:
//   i_clk          in   clock
//   i_reset        in   asynchronous active-high reset
//   i_pc           in   current fetch PC [31:2]
//   i_flush        in   redirect this cycle
//   o_fetch_stall  out  hold the fetch PC (low when a request is accepted or on flush)
//   o_imem_req     out  IMEM request valid
//   o_imem_addr    out  IMEM word address, equal to i_pc
//   i_imem_gnt     in   IMEM accepted the request
//   i_imem_rvalid  in   in-order IMEM response valid
//   i_imem_rdata   in   IMEM response word
//   o_dec_valid    out  queue head valid
//   o_dec_pc       out  queue head PC (zero when empty)
//   o_dec_instr    out  queue head instruction (zero when empty)
//   i_dec_ready    in   decode consumes the head

module rv_fetch_buf
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [29:0] i_pc,
    input  logic        i_flush,
    output logic        o_fetch_stall,
    output logic        o_imem_req,
    output logic [29:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_dec_valid,
    output logic [29:0] o_dec_pc,
    output logic [31:0] o_dec_instr,
    input  logic        i_dec_ready
);

    localparam int QW = $bits(fetch_entry_t);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic          grant;
    logic          credit_ok;
    logic          resp_keep;

    // Tag FIFO: one entry per granted request, so its occupancy is the
    // outstanding-request count; stale tags retire with their dropped responses.
    logic [29:0]   tag_pc;
    logic [OW-1:0] tag_count;
    logic          tag_full;
    logic          tag_empty;

    fetch_entry_t  q_wdata;
    fetch_entry_t  q_head;
    logic          q_push;
    logic          q_pop;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;

    // Responses still owed for requests issued before the latest redirect.
    logic [OW-1:0] discard;

    // Queued plus in-flight words may never exceed the queue depth, so every
    // response that is kept always finds a free slot.
    assign credit_ok = (int'(q_count) + int'(tag_count)) < DEPTH;

    assign o_imem_req    = ~i_reset & ~i_flush & ~tag_full & credit_ok;
    assign o_imem_addr   = i_pc;
    assign grant         = o_imem_req & i_imem_gnt;
    assign o_fetch_stall = ~grant & ~i_flush;

    assign resp_keep = i_imem_rvalid & ~i_flush & (discard == '0);

    rv_fetch_fifo #(
        .WIDTH (30),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .clr   (1'b0),
        .push  (grant),
        .wdata (i_pc),
        .pop   (i_imem_rvalid),
        .rdata (tag_pc),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    assign q_wdata.pc    = tag_pc;
    assign q_wdata.instr = i_imem_rdata;
    assign q_push        = resp_keep;
    // The head is never consumed in a redirect cycle; the clear discards it.
    assign q_pop         = o_dec_valid & i_dec_ready & ~i_flush;

    rv_fetch_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk   (i_clk),
        .rst   (i_reset),
        .clr   (i_flush),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // On redirect every request still in flight after this cycle is stale.
    // No grant is possible in a flush cycle, so that is the current count less
    // any response retiring now; this also absorbs a previous discard backlog.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            discard <= '0;
        end else if (i_flush) begin
            discard <= tag_count - OW'(i_imem_rvalid);
        end else if (i_imem_rvalid && (discard != '0)) begin
            discard <= discard - OW'(1);
        end
    end

    assign o_dec_valid = ~q_empty;
    assign o_dec_pc    = o_dec_valid ? q_head.pc    : 30'd0;
    assign o_dec_instr = o_dec_valid ? q_head.instr : 32'd0;

    a_no_q_overflow : assert property (@(posedge i_clk) disable iff (i_reset)
        !(q_push && q_full && !q_pop));

    a_no_orphan_resp : assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_imem_rvalid && tag_empty));

    a_discard_bound : assert property (@(posedge i_clk) disable iff (i_reset)
        discard <= tag_count);

endmodule

// File: tb/tb_rv_fetch_buf.sv
// tb/tb_rv_fetch_buf.sv - self-checking bench for rv_fetch_buf

module tb_rv_fetch_buf;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] pc;
    logic        flush;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        o_fetch_stall;
    logic        o_imem_req;
    logic [29:0] o_imem_addr;
    logic        o_dec_valid;
    logic [29:0] o_dec_pc;
    logic [31:0] o_dec_instr;

    always #5 clk = ~clk;

    rv_fetch_buf #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_pc          (pc),
        .i_flush       (flush),
        .o_fetch_stall (o_fetch_stall),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_dec_valid   (o_dec_valid),
        .o_dec_pc      (o_dec_pc),
        .o_dec_instr   (o_dec_instr),
        .i_dec_ready   (ready)
    );

    typedef struct { logic [29:0] pc; int due; bit stale; } req_t;
    typedef struct { logic [29:0] pc; logic [31:0] instr; } ent_t;
    typedef struct {
        bit g; bit r; bit f; logic [29:0] tgt;
        bit e_req; bit e_stall; bit e_valid; logic [29:0] e_pc;
    } vec_t;

    req_t        infl[$];
    ent_t        mq[$];
    logic [29:0] pc_q;
    logic [29:0] next_order;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          dut_inflight = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          fired;
    logic [29:0] fired_pc;
    logic        s_req, s_stall, s_valid;
    logic [29:0] s_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [29:0] a);
        return {a, 2'b11} ^ 32'h5a3c_0f00;
    endfunction

    // One clock cycle: drive, check against the queue model at the falling edge,
    // then advance the model by the events of this cycle.
    task automatic step(input bit g, input bit r, input bit f, input logic [29:0] tgt);
        bit   rv, exp_req, exp_stall;
        req_t e;
        ent_t h;
        int   lat;
        pc    = pc_q;
        gnt   = g;
        ready = r;
        flush = f;
        rv    = (infl.size() > 0) && (infl[0].due <= cyc);
        rvalid = rv;
        rdata  = rv ? instr_of(infl[0].pc) : $urandom;
        #4;
        exp_req   = !f && (infl.size() < MAXO) && ((mq.size() + infl.size()) < DEPTH);
        exp_stall = !(exp_req && g) && !f;
        s_req = o_imem_req; s_stall = o_fetch_stall; s_valid = o_dec_valid; s_pc = o_dec_pc;
        chk("imem_req", o_imem_req, exp_req);
        chk("imem_addr", o_imem_addr, pc_q);
        chk("fetch_stall", o_fetch_stall, exp_stall);
        chk("dec_valid", o_dec_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("dec_pc", o_dec_pc, mq[0].pc);
            chk("dec_instr", o_dec_instr, mq[0].instr);
        end else begin
            chk("dec_pc_idle", o_dec_pc, 0);
            chk("dec_instr_idle", o_dec_instr, 0);
        end
        fired = o_dec_valid && r && !f;
        if (fired) begin
            fired_pc = o_dec_pc;
            chk("dec_order", o_dec_pc, next_order);
            next_order = next_order + 1;
        end
        if (o_imem_req && g) dut_inflight++;
        if (rv) dut_inflight--;
        if (mq.size() > 0 && r && !f) void'(mq.pop_front());
        if (rv) begin
            e = infl.pop_front();
            if (!f && !e.stale) begin
                h.pc = e.pc; h.instr = instr_of(e.pc);
                mq.push_back(h);
            end
        end
        if (f) begin
            foreach (infl[i]) infl[i].stale = 1'b1;
            mq.delete();
            next_order = tgt;
        end
        if (exp_req && g) begin
            lat = $urandom_range(lat_max, lat_min);
            e.pc = pc_q;
            e.due = (cyc + lat > last_due) ? cyc + lat : last_due;
            e.stale = 1'b0;
            last_due = e.due;
            infl.push_back(e);
        end
        if (f) pc_q = tgt;
        else if (!exp_stall) pc_q = pc_q + 1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [29:0] start);
        rst = 1'b1; flush = 1'b0; gnt = 1'b0; ready = 1'b0; rvalid = 1'b0;
        pc = '0; rdata = '0;
        infl.delete(); mq.delete();
        pc_q = start; next_order = start; dut_inflight = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", o_imem_req, 0);
        chk("rst_stall", o_fetch_stall, 1);
        chk("rst_valid", o_dec_valid, 0);
        chk("rst_pc", o_dec_pc, 0);
        chk("rst_instr", o_dec_instr, 0);
        rst = 1'b0;
        last_due = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        bit   saw_first;
        tbl[0]  = '{1, 1, 0, 30'h0,  1, 0, 0, 30'h0};
        tbl[1]  = '{1, 1, 0, 30'h0,  1, 0, 0, 30'h0};
        tbl[2]  = '{1, 1, 0, 30'h0,  1, 0, 1, 30'h0};
        tbl[3]  = '{1, 0, 0, 30'h0,  1, 0, 1, 30'h1};
        tbl[4]  = '{1, 0, 0, 30'h0,  1, 0, 1, 30'h1};
        tbl[5]  = '{1, 0, 0, 30'h0,  0, 1, 1, 30'h1};
        tbl[6]  = '{1, 0, 0, 30'h0,  0, 1, 1, 30'h1};
        tbl[7]  = '{1, 1, 0, 30'h0,  0, 1, 1, 30'h1};
        tbl[8]  = '{1, 1, 0, 30'h0,  1, 0, 1, 30'h2};
        tbl[9]  = '{1, 1, 0, 30'h0,  1, 0, 1, 30'h3};
        tbl[10] = '{1, 1, 1, 30'h10, 0, 0, 1, 30'h4};
        tbl[11] = '{1, 1, 0, 30'h0,  1, 0, 0, 30'h0};
        tbl[12] = '{1, 1, 0, 30'h0,  1, 0, 0, 30'h0};
        tbl[13] = '{1, 1, 0, 30'h0,  1, 0, 1, 30'h10};

        // Streaming start-up, back-pressure to a full queue, resume, redirect.
        lat_min = 1; lat_max = 1;
        do_reset(30'h0);
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].g, tbl[i].r, tbl[i].f, tbl[i].tgt);
            chk($sformatf("vec%0d_req", i), s_req, tbl[i].e_req);
            chk($sformatf("vec%0d_stall", i), s_stall, tbl[i].e_stall);
            chk($sformatf("vec%0d_valid", i), s_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d_pc", i), s_pc, tbl[i].e_pc);
        end

        // Three-cycle IMEM latency: in-flight count stays within the cap.
        lat_min = 3; lat_max = 3;
        do_reset(30'h100);
        for (int i = 0; i < 30; i++) begin
            step(1, 1, 0, 30'h0);
            chk("max_outstanding", dut_inflight <= MAXO, 1);
        end

        // Redirect with two requests in flight: both responses dropped.
        do_reset(30'h0);
        step(1, 1, 0, 30'h0);
        step(1, 1, 0, 30'h0);
        chk("two_in_flight", dut_inflight, 2);
        step(1, 1, 1, 30'h10);
        saw_first = 1'b0;
        for (int i = 0; i < 20 && !saw_first; i++) begin
            step(1, 1, 0, 30'h0);
            saw_first = fired;
        end
        chk("flush_first_seen", saw_first, 1);
        chk("flush_first_pc", fired_pc, 30'h10);

        // Redirect in the same cycle as a response and a decode pop.
        lat_min = 1; lat_max = 1;
        do_reset(30'h200);
        repeat (4) step(1, 1, 0, 30'h0);
        chk("pre_flush_rvalid", rvalid, 1);
        step(1, 1, 1, 30'h20);
        step(1, 1, 0, 30'h0);
        chk("post_flush_empty", s_valid, 0);

        // Asynchronous reset mid-stream, applied away from the clock edge.
        repeat (5) step(1, 1, 0, 30'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_req", o_imem_req, 0);
        chk("async_stall", o_fetch_stall, 1);
        chk("async_valid", o_dec_valid, 0);
        chk("async_pc", o_dec_pc, 0);
        chk("async_instr", o_dec_instr, 0);
        @(posedge clk);
        #1;
        cyc++;
        do_reset(30'h300);

        // Randomised traffic against the queue model.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 80,
                 $urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 75 : 25),
                 $urandom_range(0, 99) < 3,
                 30'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
